// File: rtl/online_div_seq_ctrl.sv
// Sequencer for the radix-2 online-division residue datapath: phase FSM plus enable decode, no arithmetic.
// Define STALL_WDOG_EN to add the stall watchdog and the o_err port.
module online_div_seq_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int DELTA    = 3,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_digit_in_valid,
    output logic             o_digit_ready,
    output logic             o_in_zero,
    output logic             o_residue_clr,
    output logic             o_residue_en,
    output logic             o_sel_en,
    output logic             o_q_valid,
    output logic             o_q_last,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_digit_cnt
`ifdef STALL_WDOG_EN
    ,
    output logic             o_err
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(DELTA - 1);
    localparam logic [CNT_W-1:0] ITER_LAST  = CNT_W'(N_DIGITS - DELTA - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(DELTA - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q_valid;
    logic             r_q_last;

    logic             w_feed;
    logic             w_flush;
    logic             w_accept;
    logic             w_sel_en;
    logic             w_count;
    logic             w_phase_last;
    logic             w_phase_end;
    logic             w_q_last_nxt;
    logic             w_wdog_trip;

    // Phase decode: which cycles feed operand digits and which advance the phase counter
    always_comb begin
        w_feed       = (r_state == S_INIT) || (r_state == S_ITER);
        w_flush      = (r_state == S_FLUSH);
        w_accept     = w_feed & i_digit_in_valid;
        w_sel_en     = ((r_state == S_ITER) & i_digit_in_valid) | w_flush;
        w_count      = w_accept | w_flush;
        w_q_last_nxt = w_flush & (r_cnt == FLUSH_LAST);
    end

    // Last-count detection for the phase currently running
    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            S_INIT:  w_phase_last = (r_cnt == INIT_LAST);
            S_ITER:  w_phase_last = (r_cnt == ITER_LAST);
            S_FLUSH: w_phase_last = (r_cnt == FLUSH_LAST);
            default: w_phase_last = 1'b0;
        endcase
        w_phase_end = w_count & w_phase_last;
    end

`ifdef STALL_WDOG_EN
    logic [3:0] r_wdog;
    logic       w_stall;

    // Watchdog trips on the 15th consecutive stalled feed cycle
    always_comb begin
        w_stall     = w_feed & ~i_digit_in_valid;
        w_wdog_trip = w_stall & (r_wdog == 4'd14);
    end

    // Consecutive-stall counter; any accepted digit or leaving the feed phases clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 4'd0;
        end else if (w_stall && !w_wdog_trip) begin
            r_wdog <= r_wdog + 4'd1;
        end else begin
            r_wdog <= 4'd0;
        end
    end

    assign o_err = w_wdog_trip;
`else
    assign w_wdog_trip = 1'b0;
`endif

    // Next-state logic; a watchdog trip abandons the division without done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CLR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLR: w_state_nxt = S_INIT;
            S_INIT: begin
                if (w_wdog_trip) begin
                    w_state_nxt = S_IDLE;
                end else if (w_phase_end) begin
                    w_state_nxt = S_ITER;
                end else begin
                    w_state_nxt = S_INIT;
                end
            end
            S_ITER: begin
                if (w_wdog_trip) begin
                    w_state_nxt = S_IDLE;
                end else if (w_phase_end) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_ITER;
                end
            end
            S_FLUSH: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state change and holds through stalls
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (w_count) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State, phase counter and quotient-strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_ZERO;
            r_q_valid <= 1'b0;
            r_q_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_q_valid <= w_sel_en;
            r_q_last  <= w_q_last_nxt;
        end
    end

    assign o_digit_ready = w_feed;
    assign o_in_zero     = w_flush;
    assign o_residue_clr = (r_state == S_CLR);
    assign o_residue_en  = w_accept | w_flush;
    assign o_sel_en      = w_sel_en;
    assign o_q_valid     = r_q_valid;
    assign o_q_last      = r_q_last;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_digit_cnt   = r_cnt;

endmodule
